tlb_port_arbiter: RTL and testbench

Shares the single TLB search/read/write port between the fetch-stage lookup, the memory-stage lookup and the writeback-stage TLB maintenance instructions (tlbsrch, tlbrd, tlbwr, tlbfill). It sits beside the TLB array, fed by the IF, EX/MEM and WB stages. It serialises maintenance ops against lookups and generates the tlbfill replacement index. It also raises the one-cycle post-write refetch flush.

---
 rtl/tlb_port_arbiter_pkg.sv | 32 +++
 rtl/tlb_port_arbiter_fill_idx_gen.sv | 27 ++
 rtl/tlb_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_tlb_port_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_port_arbiter_pkg.sv
// tlb_port_arbiter_pkg
//   Shared definitions for the TLB port arbiter: maintenance op encodings
//   as they arrive from WB, the default TLB geometry and the arbiter FSM
//   state type.
package tlb_port_arbiter_pkg;

  // Maintenance op encodings on wb_op; any other value is ignored.
  localparam logic [2:0] TLBOP_SRCH = 3'd1;
  localparam logic [2:0] TLBOP_RD   = 3'd2;
  localparam logic [2:0] TLBOP_WR   = 3'd3;
  localparam logic [2:0] TLBOP_FILL = 3'd4;

  // Default TLB geometry.
  localparam int TLBNUM_DEF = 16;
  localparam int TLBNUM_IDX = $clog2(TLBNUM_DEF);

  // Arbiter FSM states. TLBWR and TLBFILL share ST_OP_WR; they differ only
  // in where the write index comes from, which is decided at acceptance.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OP_SRCH = 3'd1,
    ST_OP_RD   = 3'd2,
    ST_OP_WR   = 3'd3,
    ST_POST_WR = 3'd4
  } arb_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == TLBOP_SRCH) || (op == TLBOP_RD) ||
           (op == TLBOP_WR)   || (op == TLBOP_FILL);
  endfunction

endpackage

// File: rtl/tlb_port_arbiter_fill_idx_gen.sv
// tlb_fill_idx_gen
//   Free-running replacement index for tlbfill. Advances every cycle and
//   wraps TLBNUM-1 -> 0; the arbiter samples it when a FILL is accepted.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset (counter -> 0)
//   fill_idx out  current replacement index
module tlb_fill_idx_gen #(
  parameter  int TLBNUM = 16,
  localparam int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] fill_idx
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_idx <= '0;
    end else if (fill_idx == IDX_W'(TLBNUM - 1)) begin
      fill_idx <= '0;
    end else begin
      fill_idx <= fill_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tlb_port_arbiter.sv
// tlb_port_arbiter
//   Shares the single TLB search/read/write port between the IF lookup, the
//   MEM lookup and WB maintenance ops (tlbsrch/tlbrd/tlbwr/tlbfill).
//   Maintenance ops are serialised against lookups; after any write a
//   one-cycle refetch_flush is raised.
//
// Handshakes: a lookup requester holds req and vaddr until gnt is seen in
//   the same cycle (gnt is combinational); its result appears one cycle
//   later on <x>_rsp_valid with rsp_found/rsp_idx/rsp_data. A WB op is
//   presented with wb_op_valid and is taken in the cycle wb_op_ready is
//   high; wb_op_done pulses once when it completes.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      WB flush; kills last cycle's lookup response,
//                              blocks grants and op acceptance this cycle
//   if_/mem_ req,vaddr,gnt     lookup requests and grants
//   if_/mem_ rsp_valid         lookup response valid
//   rsp_found/idx/data         registered lookup result (rsp_data also
//                              captures tlbrd data)
//   wb_op_valid/op/vaddr/idx   maintenance op from WB
//   wb_op_ready/done           op accept / completion pulse
//   wb_srch_found/idx          tlbsrch result, valid with wb_op_done
//   tlb_s_*, tlb_r*, tlb_w*    TLB array search/read/write port
//   refetch_flush              one-cycle pulse after a TLB write
//   dbg_state                  current FSM state (arb_state_e encoding)
//
// Build option: define TLB_STARVE_GUARD_EN to let a waiting fetch win after
//   STARVE_MAX consecutive mem grants; otherwise mem strictly beats fetch.
module tlb_port_arbiter
  import tlb_port_arbiter_pkg::*;
#(
  parameter  int TLBNUM     = 16,
  parameter  int ENTRY_W    = 89,
  parameter  int STARVE_MAX = 4,
  localparam int IDX_W      = (TLBNUM == TLBNUM_DEF) ? TLBNUM_IDX : $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               if_req,
  input  logic [31:0]        if_vaddr,
  output logic               if_gnt,
  output logic               if_rsp_valid,
  input  logic               mem_req,
  input  logic [31:0]        mem_vaddr,
  output logic               mem_gnt,
  output logic               mem_rsp_valid,
  output logic               rsp_found,
  output logic [IDX_W-1:0]   rsp_idx,
  output logic [ENTRY_W-1:0] rsp_data,
  input  logic               wb_op_valid,
  input  logic [2:0]         wb_op,
  input  logic [31:0]        wb_op_vaddr,
  input  logic [IDX_W-1:0]   wb_op_idx,
  output logic               wb_op_ready,
  output logic               wb_op_done,
  output logic               wb_srch_found,
  output logic [IDX_W-1:0]   wb_srch_idx,
  output logic               tlb_s_valid,
  output logic [31:0]        tlb_s_vaddr,
  input  logic               tlb_s_found,
  input  logic [IDX_W-1:0]   tlb_s_idx,
  input  logic [ENTRY_W-1:0] tlb_s_data,
  output logic               tlb_re,
  output logic [IDX_W-1:0]   tlb_r_idx,
  input  logic [ENTRY_W-1:0] tlb_r_data,
  output logic               tlb_we,
  output logic [IDX_W-1:0]   tlb_w_idx,
  output logic               refetch_flush,
  output logic [2:0]         dbg_state
);

  arb_state_e         state_q;
  logic [31:0]        vaddr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   fill_idx;
  logic               if_rsp_q;
  logic               mem_rsp_q;
  logic               srch_found_q;
  logic [IDX_W-1:0]   srch_idx_q;
  logic               op_accept;
  logic               arb_ok;
  logic               mem_wins;
  logic               starve_force;

  tlb_fill_idx_gen #(.TLBNUM(TLBNUM)) u_fill_idx_gen (
    .clk      (clk),
    .reset    (reset),
    .fill_idx (fill_idx)
  );

  // Reset is folded in so no grant or accept leaks out while reset is held.
  assign op_accept = !reset && (state_q == ST_IDLE) && wb_op_valid && !flush &&
                     op_legal(wb_op);
  assign arb_ok    = !reset && (state_q == ST_IDLE) && !flush && !op_accept;

`ifdef TLB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q;

  // Counts back-to-back mem grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!if_req || if_gnt) begin
      starve_q <= '0;
    end else if (mem_gnt) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign starve_force = (starve_q >= STARVE_W'(STARVE_MAX));
`else
  // Strict mem-over-fetch priority; the threshold has no effect here.
  logic starve_cfg_unused;
  assign starve_cfg_unused = (STARVE_MAX > 0);
  assign starve_force      = 1'b0;
`endif

  assign mem_wins = mem_req && !(starve_force && if_req);
  assign mem_gnt  = arb_ok && mem_wins;
  assign if_gnt   = arb_ok && if_req && !mem_wins;

  // TLB port drive, decoded from the registered state.
  always_comb begin
    tlb_s_valid = 1'b0;
    tlb_s_vaddr = '0;
    if (state_q == ST_OP_SRCH) begin
      tlb_s_valid = 1'b1;
      tlb_s_vaddr = vaddr_q;
    end else if (mem_gnt) begin
      tlb_s_valid = 1'b1;
      tlb_s_vaddr = mem_vaddr;
    end else if (if_gnt) begin
      tlb_s_valid = 1'b1;
      tlb_s_vaddr = if_vaddr;
    end
  end

  assign tlb_re        = (state_q == ST_OP_RD);
  assign tlb_r_idx     = (state_q == ST_OP_RD) ? idx_q : '0;
  assign tlb_we        = (state_q == ST_OP_WR);
  assign tlb_w_idx     = (state_q == ST_OP_WR) ? idx_q : '0;
  assign wb_op_ready   = op_accept;
  assign wb_op_done    = (state_q == ST_OP_SRCH) || (state_q == ST_OP_RD) ||
                         (state_q == ST_OP_WR);
  assign refetch_flush = (state_q == ST_POST_WR);
  assign dbg_state     = state_q;

  // The search result is passed straight through in the done cycle and held
  // afterwards so WB can also read it later.
  assign wb_srch_found = (state_q == ST_OP_SRCH) ? tlb_s_found : srch_found_q;
  assign wb_srch_idx   = (state_q == ST_OP_SRCH) ? tlb_s_idx   : srch_idx_q;

  // A flush in the response cycle kills the response of last cycle's grant.
  assign if_rsp_valid  = if_rsp_q  && !flush;
  assign mem_rsp_valid = mem_rsp_q && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vaddr_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_accept) begin
            vaddr_q <= wb_op_vaddr;
            // FILL takes the replacement index as it reads at acceptance.
            idx_q   <= (wb_op == TLBOP_FILL) ? fill_idx : wb_op_idx;
            case (wb_op)
              TLBOP_SRCH: state_q <= ST_OP_SRCH;
              TLBOP_RD:   state_q <= ST_OP_RD;
              default:    state_q <= ST_OP_WR;
            endcase
          end
        end
        ST_OP_SRCH: state_q <= ST_IDLE;
        ST_OP_RD:   state_q <= ST_IDLE;
        ST_OP_WR:   state_q <= ST_POST_WR;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rsp_q     <= 1'b0;
      mem_rsp_q    <= 1'b0;
      rsp_found    <= 1'b0;
      rsp_idx      <= '0;
      rsp_data     <= '0;
      srch_found_q <= 1'b0;
      srch_idx_q   <= '0;
    end else begin
      if_rsp_q  <= if_gnt;
      mem_rsp_q <= mem_gnt;
      if (if_gnt || mem_gnt) begin
        rsp_found <= tlb_s_found;
        rsp_idx   <= tlb_s_idx;
        rsp_data  <= tlb_s_data;
      end else if (state_q == ST_OP_RD) begin
        rsp_data  <= tlb_r_data;
      end
      if (state_q == ST_OP_SRCH) begin
        srch_found_q <= tlb_s_found;
        srch_idx_q   <= tlb_s_idx;
      end
    end
  end

endmodule

// File: tb/tb_tlb_port_arbiter.sv
module tb_tlb_port_arbiter;
  import tlb_port_arbiter_pkg::*;

  localparam int TLBNUM     = 16;
  localparam int IDX_W      = 4;
  localparam int ENTRY_W    = 89;
  localparam int STARVE_MAX = 4;
`ifdef TLB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               flush;
  logic               if_req, mem_req;
  logic [31:0]        if_vaddr, mem_vaddr;
  logic               if_gnt, mem_gnt, if_rsp_valid, mem_rsp_valid;
  logic               rsp_found;
  logic [IDX_W-1:0]   rsp_idx;
  logic [ENTRY_W-1:0] rsp_data;
  logic               wb_op_valid;
  logic [2:0]         wb_op;
  logic [31:0]        wb_op_vaddr;
  logic [IDX_W-1:0]   wb_op_idx;
  logic               wb_op_ready, wb_op_done, wb_srch_found;
  logic [IDX_W-1:0]   wb_srch_idx;
  logic               tlb_s_valid;
  logic [31:0]        tlb_s_vaddr;
  logic               tlb_s_found;
  logic [IDX_W-1:0]   tlb_s_idx;
  logic [ENTRY_W-1:0] tlb_s_data;
  logic               tlb_re, tlb_we, refetch_flush;
  logic [IDX_W-1:0]   tlb_r_idx, tlb_w_idx;
  logic [ENTRY_W-1:0] tlb_r_data;
  logic [2:0]         dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  tlb_port_arbiter #(.TLBNUM(TLBNUM), .ENTRY_W(ENTRY_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_req(if_req), .if_vaddr(if_vaddr), .if_gnt(if_gnt), .if_rsp_valid(if_rsp_valid),
    .mem_req(mem_req), .mem_vaddr(mem_vaddr), .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid),
    .rsp_found(rsp_found), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
    .wb_op_valid(wb_op_valid), .wb_op(wb_op), .wb_op_vaddr(wb_op_vaddr), .wb_op_idx(wb_op_idx),
    .wb_op_ready(wb_op_ready), .wb_op_done(wb_op_done),
    .wb_srch_found(wb_srch_found), .wb_srch_idx(wb_srch_idx),
    .tlb_s_valid(tlb_s_valid), .tlb_s_vaddr(tlb_s_vaddr), .tlb_s_found(tlb_s_found),
    .tlb_s_idx(tlb_s_idx), .tlb_s_data(tlb_s_data),
    .tlb_re(tlb_re), .tlb_r_idx(tlb_r_idx), .tlb_r_data(tlb_r_data),
    .tlb_we(tlb_we), .tlb_w_idx(tlb_w_idx), .refetch_flush(refetch_flush),
    .dbg_state(dbg_state)
  );

  // ---------------- TLB array environment ----------------
  logic [18:0]        tlb_vpn  [TLBNUM];
  logic [ENTRY_W-1:0] tlb_data [TLBNUM];
  int                 s_hit;

  function automatic int find_idx(input logic [31:0] va);
    for (int i = 0; i < TLBNUM; i++) if (tlb_vpn[i] == va[31:13]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_va();
    if ($urandom_range(0, 1) == 1) return {tlb_vpn[$urandom_range(0, TLBNUM-1)], 13'($urandom)};
    return $urandom;
  endfunction

  always_comb begin
    s_hit       = find_idx(tlb_s_vaddr);
    tlb_s_found = (s_hit >= 0);
    tlb_s_idx   = (s_hit >= 0) ? IDX_W'(s_hit) : '0;
    tlb_s_data  = (s_hit >= 0) ? tlb_data[s_hit] : '0;
  end
  assign tlb_r_data = tlb_data[tlb_r_idx];

  // Replacement index as the environment sees it: counts cycles since reset.
  logic [IDX_W-1:0] fill_model;
  always @(posedge clk or posedge reset)
    if (reset) fill_model <= '0;
    else       fill_model <= fill_model + 1'b1;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush = 0; if_req = 0; mem_req = 0; if_vaddr = 0; mem_vaddr = 0;
    wb_op_valid = 0; wb_op = 0; wb_op_vaddr = 0; wb_op_idx = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; if_req = 1; mem_req = 1; if_vaddr = 32'h1C00_0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({if_gnt, mem_gnt, if_rsp_valid, mem_rsp_valid, wb_op_ready, wb_op_done,
         tlb_s_valid, tlb_re, tlb_we, refetch_flush} !== 10'b0) begin
      n_bad++; $display("FAIL reset_strobes got=%b want=0", {if_gnt, mem_gnt, if_rsp_valid,
        mem_rsp_valid, wb_op_ready, wb_op_done, tlb_s_valid, tlb_re, tlb_we, refetch_flush});
    end
    n_cmp++;
    if (rsp_found !== 0 || rsp_idx !== 0 || rsp_data !== 0 || wb_srch_found !== 0 || wb_srch_idx !== 0) begin
      n_bad++; $display("FAIL reset_results found=%b idx=%0d srch=%b/%0d want all 0",
        rsp_found, rsp_idx, wb_srch_found, wb_srch_idx);
    end
    n_cmp++;
    if (tlb_s_vaddr !== 0 || tlb_r_idx !== 0 || tlb_w_idx !== 0 || dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL reset_port s_vaddr=%h r_idx=%0d w_idx=%0d state=%0d want 0",
        tlb_s_vaddr, tlb_r_idx, tlb_w_idx, dbg_state);
    end
    @(negedge clk);
    reset = 0; idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_fetch_hit();
    @(negedge clk);
    if_req = 1; if_vaddr = 32'h1C00_0000;
    #1;
    n_cmp++;
    if ({if_gnt, mem_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL fetch_gnt got=%b want=10", {if_gnt, mem_gnt});
    end
    @(negedge clk);
    if_req = 0;
    #1;
    n_cmp++;
    if ({if_rsp_valid, mem_rsp_valid, rsp_found} !== 3'b101 || rsp_idx !== 4'd5) begin
      n_bad++; $display("FAIL fetch_rsp got v=%b f=%b idx=%0d want v=10 f=1 idx=5",
        {if_rsp_valid, mem_rsp_valid}, rsp_found, rsp_idx);
    end
    n_cmp++;
    if (rsp_data !== tlb_data[5]) begin
      n_bad++; $display("FAIL fetch_data got=%h want=%h", rsp_data, tlb_data[5]);
    end
  endtask

  task automatic test_arb_pattern();
    bit exp_mem;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req = 1; mem_req = 1; if_vaddr = rand_va(); mem_vaddr = rand_va();
      #1;
      exp_mem = GUARD ? ((i % (STARVE_MAX + 1)) != STARVE_MAX) : 1'b1;
      n_cmp++;
      if ({if_gnt, mem_gnt} !== {!exp_mem, exp_mem}) begin
        n_bad++; $display("FAIL arb_pattern cyc=%0d got=%b want=%b", i, {if_gnt, mem_gnt}, {!exp_mem, exp_mem});
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_srch();
    // Miss while mem is requesting: op wins the port.
    @(negedge clk);
    wb_op_valid = 1; wb_op = TLBOP_SRCH; wb_op_vaddr = 32'h0040_0000; mem_req = 1; mem_vaddr = rand_va();
    #1;
    n_cmp++;
    if ({wb_op_ready, mem_gnt, if_gnt} !== 3'b100) begin
      n_bad++; $display("FAIL srch_accept got rdy/mg/ig=%b want=100", {wb_op_ready, mem_gnt, if_gnt});
    end
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if ({wb_op_done, wb_srch_found, mem_gnt} !== 3'b100) begin
      n_bad++; $display("FAIL srch_miss got done/found/mg=%b want=100", {wb_op_done, wb_srch_found, mem_gnt});
    end
    @(negedge clk);
    mem_req = 0;
    #1;
    n_cmp++;
    if (wb_op_done !== 0) begin
      n_bad++; $display("FAIL srch_done_pulse got=%b want=0", wb_op_done);
    end
    // Hit on entry 9.
    wb_op_valid = 1; wb_op = TLBOP_SRCH; wb_op_vaddr = {tlb_vpn[9], 13'h0ABC};
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if ({wb_op_done, wb_srch_found} !== 2'b11 || wb_srch_idx !== 4'd9) begin
      n_bad++; $display("FAIL srch_hit got done/found=%b idx=%0d want 11 idx=9",
        {wb_op_done, wb_srch_found}, wb_srch_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_rd();
    @(negedge clk);
    wb_op_valid = 1; wb_op = TLBOP_RD; wb_op_idx = 4'd3; if_req = 1; if_vaddr = rand_va();
    #1;
    n_cmp++;
    if ({wb_op_ready, if_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rd_accept got rdy/ig=%b want=10", {wb_op_ready, if_gnt});
    end
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if ({wb_op_done, tlb_re, if_gnt, if_rsp_valid} !== 4'b1100 || tlb_r_idx !== 4'd3) begin
      n_bad++; $display("FAIL rd_cycle got done/re/ig/rv=%b ridx=%0d want 1100 ridx=3",
        {wb_op_done, tlb_re, if_gnt, if_rsp_valid}, tlb_r_idx);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_data !== tlb_data[3] || if_rsp_valid !== 0 || if_gnt !== 1) begin
      n_bad++; $display("FAIL rd_data got=%h rv=%b ig=%b want=%h rv=0 ig=1",
        rsp_data, if_rsp_valid, if_gnt, tlb_data[3]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_fill();
    bit hit7 = 0;
    for (int k = 0; k < 40 && !hit7; k++) begin
      @(negedge clk);
      if (fill_model == 4'd7) hit7 = 1;
    end
    n_cmp++;
    if (!hit7) begin
      n_bad++; $display("FAIL fill_wait got=timeout want=counter 7");
      return;
    end
    wb_op_valid = 1; wb_op = TLBOP_FILL; if_req = 1; mem_req = 1;
    #1;
    n_cmp++;
    if ({wb_op_ready, if_gnt, mem_gnt} !== 3'b100) begin
      n_bad++; $display("FAIL fill_accept got rdy/ig/mg=%b want=100", {wb_op_ready, if_gnt, mem_gnt});
    end
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if ({tlb_we, wb_op_done, refetch_flush, if_gnt, mem_gnt} !== 5'b11000 || tlb_w_idx !== 4'd7) begin
      n_bad++; $display("FAIL fill_write got we/done/rf/ig/mg=%b widx=%0d want 11000 widx=7",
        {tlb_we, wb_op_done, refetch_flush, if_gnt, mem_gnt}, tlb_w_idx);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({refetch_flush, tlb_we, wb_op_done, if_gnt, mem_gnt} !== 5'b10000) begin
      n_bad++; $display("FAIL fill_refetch got rf/we/done/ig/mg=%b want=10000",
        {refetch_flush, tlb_we, wb_op_done, if_gnt, mem_gnt});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({refetch_flush, mem_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL fill_resume got rf/mg=%b want=01", {refetch_flush, mem_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    mem_req = 1; mem_vaddr = rand_va();
    #1;
    n_cmp++;
    if (mem_gnt !== 1) begin
      n_bad++; $display("FAIL flush_pre_gnt got=%b want=1", mem_gnt);
    end
    @(negedge clk);
    flush = 1; if_req = 1; wb_op_valid = 1; wb_op = TLBOP_SRCH;
    #1;
    n_cmp++;
    if ({mem_rsp_valid, mem_gnt, if_gnt, wb_op_ready} !== 4'b0000) begin
      n_bad++; $display("FAIL flush_kill got rv/mg/ig/rdy=%b want=0000",
        {mem_rsp_valid, mem_gnt, if_gnt, wb_op_ready});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if ({mem_rsp_valid, if_rsp_valid, dbg_state} !== 5'b0) begin
      n_bad++; $display("FAIL flush_after got rv=%b state=%0d want rv=00 state=0",
        {mem_rsp_valid, if_rsp_valid}, dbg_state);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    wb_op_valid = 1; wb_op = TLBOP_WR; wb_op_idx = 4'd9;
    #1;
    n_cmp++;
    if (wb_op_ready !== 1) begin
      n_bad++; $display("FAIL rst_op_accept got=%b want=1", wb_op_ready);
    end
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if (tlb_we !== 1 || tlb_w_idx !== 4'd9) begin
      n_bad++; $display("FAIL rst_op_write got we=%b widx=%0d want we=1 widx=9", tlb_we, tlb_w_idx);
    end
    #1 reset = 1;
    #1;
    n_cmp++;
    if ({tlb_we, wb_op_done, refetch_flush, dbg_state} !== 6'b0) begin
      n_bad++; $display("FAIL rst_op_drop got we/done/rf=%b state=%0d want 000 state=0",
        {tlb_we, wb_op_done, refetch_flush}, dbg_state);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({wb_op_done, refetch_flush} !== 2'b00) begin
      n_bad++; $display("FAIL rst_op_nodone got done/rf=%b want=00", {wb_op_done, refetch_flush});
    end
    // First FILL after reset must see the replacement index back at 0.
    @(negedge clk);
    reset = 0;
    wb_op_valid = 1; wb_op = TLBOP_FILL;
    @(negedge clk);
    wb_op_valid = 0;
    #1;
    n_cmp++;
    if (tlb_we !== 1 || tlb_w_idx !== 4'd0) begin
      n_bad++; $display("FAIL rst_fill_idx got we=%b widx=%0d want we=1 widx=0", tlb_we, tlb_w_idx);
    end
    repeat (3) @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  // Randomised traffic against a cycle-level reference of the arbitration rules.
  task automatic test_random();
    int op_age = -1;
    int m_len = 0;
    logic [2:0] m_op = 0;
    logic [IDX_W-1:0] m_idx = 0;
    logic [31:0] m_va = 0;
    bit prev_if = 0, prev_mem = 0;
    int sc = 0;
    bit known_fi = 0, known_d = 0;
    logic m_found = 0;
    logic [IDX_W-1:0] m_ridx = 0;
    logic [ENTRY_W-1:0] m_rdata = 0;
    bit if_pend = 0, mem_pend = 0, op_pend = 0;
    bit idle, e_rdy, arb, e_if, e_mem, e_we, e_re, legal;
    int h;
    logic [31:0] win_va;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (!if_pend)  begin if_req  = ($urandom_range(0, 2) != 0); if_vaddr  = rand_va(); end
      if (!mem_pend) begin mem_req = ($urandom_range(0, 2) != 0); mem_vaddr = rand_va(); end
      flush = ($urandom_range(0, 7) == 0);
      if (!op_pend) begin
        wb_op_valid = ($urandom_range(0, 5) == 0);
        wb_op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
        wb_op_vaddr = rand_va();
        wb_op_idx = IDX_W'($urandom_range(0, TLBNUM-1));
      end
      #1;
      legal = (wb_op >= 3'd1) && (wb_op <= 3'd4);
      idle  = (op_age < 0);
      e_rdy = idle && wb_op_valid && !flush && legal;
      arb   = idle && !flush && !e_rdy;
      e_mem = arb && mem_req && !(GUARD && sc >= STARVE_MAX && if_req);
      e_if  = arb && if_req && !e_mem;
      e_we  = (op_age == 1) && (m_op == TLBOP_WR || m_op == TLBOP_FILL);
      e_re  = (op_age == 1) && (m_op == TLBOP_RD);

      n_cmp++;
      if ({if_gnt, mem_gnt, wb_op_ready} !== {e_if, e_mem, e_rdy}) begin
        n_bad++; $display("FAIL rnd_gnt cyc=%0d got ig/mg/rdy=%b want=%b", cyc,
          {if_gnt, mem_gnt, wb_op_ready}, {e_if, e_mem, e_rdy});
      end
      n_cmp++;
      if ({if_rsp_valid, mem_rsp_valid} !== {prev_if && !flush, prev_mem && !flush}) begin
        n_bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc,
          {if_rsp_valid, mem_rsp_valid}, {prev_if && !flush, prev_mem && !flush});
      end
      n_cmp++;
      if ({wb_op_done, refetch_flush, tlb_we, tlb_re} !== {op_age == 1, op_age == 2, e_we, e_re}) begin
        n_bad++; $display("FAIL rnd_op_strobes cyc=%0d got done/rf/we/re=%b want=%b", cyc,
          {wb_op_done, refetch_flush, tlb_we, tlb_re}, {op_age == 1, op_age == 2, e_we, e_re});
      end
      if (e_we) begin
        n_cmp++;
        if (tlb_w_idx !== m_idx) begin
          n_bad++; $display("FAIL rnd_w_idx cyc=%0d got=%0d want=%0d", cyc, tlb_w_idx, m_idx);
        end
      end
      if (e_re) begin
        n_cmp++;
        if (tlb_r_idx !== m_idx) begin
          n_bad++; $display("FAIL rnd_r_idx cyc=%0d got=%0d want=%0d", cyc, tlb_r_idx, m_idx);
        end
      end
      if (op_age == 1 && m_op == TLBOP_SRCH) begin
        h = find_idx(m_va);
        n_cmp++;
        if (wb_srch_found !== (h >= 0) || (h >= 0 && wb_srch_idx !== IDX_W'(h))) begin
          n_bad++; $display("FAIL rnd_srch cyc=%0d got f=%b idx=%0d want hit=%0d", cyc,
            wb_srch_found, wb_srch_idx, h);
        end
      end
      if (known_fi) begin
        n_cmp++;
        if (rsp_found !== m_found || rsp_idx !== m_ridx) begin
          n_bad++; $display("FAIL rnd_rsp cyc=%0d got f=%b idx=%0d want f=%b idx=%0d", cyc,
            rsp_found, rsp_idx, m_found, m_ridx);
        end
      end
      if (known_d) begin
        n_cmp++;
        if (rsp_data !== m_rdata) begin
          n_bad++; $display("FAIL rnd_rsp_data cyc=%0d got=%h want=%h", cyc, rsp_data, m_rdata);
        end
      end

      // Advance the reference to the next cycle.
      if (e_mem || e_if) begin
        win_va = e_mem ? mem_vaddr : if_vaddr;
        h = find_idx(win_va);
        m_found = (h >= 0);
        m_ridx  = (h >= 0) ? IDX_W'(h) : '0;
        m_rdata = (h >= 0) ? tlb_data[h] : '0;
        known_fi = 1; known_d = 1;
      end else if (e_re) begin
        m_rdata = tlb_data[m_idx];
        known_d = 1;
      end
      if (!if_req || e_if) sc = 0;
      else if (e_mem)      sc++;
      prev_if  = e_if;
      prev_mem = e_mem;
      if_pend  = if_req && !e_if;
      mem_pend = mem_req && !e_mem;
      op_pend  = wb_op_valid && legal && !e_rdy;
      if (op_age >= 0) begin
        op_age++;
        if (op_age > m_len) op_age = -1;
      end
      if (e_rdy) begin
        op_age = 1;
        m_op   = wb_op;
        m_len  = (wb_op == TLBOP_SRCH || wb_op == TLBOP_RD) ? 1 : 2;
        m_idx  = (wb_op == TLBOP_FILL) ? fill_model : wb_op_idx;
        m_va   = wb_op_vaddr;
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < TLBNUM; i++) begin
      tlb_vpn[i]  = 19'h10000 + 19'(i * 3);
      tlb_data[i] = {25'(i), 32'($urandom), 32'($urandom)};
    end
    tlb_vpn[5] = 19'h0E000;  // vaddr 0x1C00_0000
    test_reset();
    test_fetch_hit();
    test_arb_pattern();
    test_srch();
    test_rd();
    test_fill();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
